// File: rtl/data_island_packet_scheduler.sv
// HDMI data-island slot scheduler: arbitrates ACR, audio sample, AVI and audio InfoFrame packets.
// Optional build macro HDMI_SCHED_DROP_COUNT_EN adds a saturating dropped_sample_count output.
module data_island_packet_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ACR_PERIOD = 25200
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        packet_enable,
  input  logic        frame_start,
  input  logic        audio_sample_valid,
  output logic        audio_sample_ready,
  input  logic [23:0] audio_sample_word_l,
  input  logic [23:0] audio_sample_word_r,
  output logic [7:0]  packet_type,
  output logic [23:0] sample_word_l,
  output logic [23:0] sample_word_r,
`ifdef HDMI_SCHED_DROP_COUNT_EN
  output logic [15:0] dropped_sample_count,
`endif
  output logic        audio_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = $clog2(ACR_PERIOD);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LVL = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACR_PERIOD - 1);

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  logic [23:0]      fifo_l_r [FIFO_DEPTH];
  logic [23:0]      fifo_r_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [TMR_W-1:0] acr_timer_r;
  logic             acr_pending_r;
  logic             avi_pending_r;
  logic             aif_pending_r;
  logic             overflow_r;
  logic [7:0]       packet_type_r;
  logic [23:0]      sample_word_l_r;
  logic [23:0]      sample_word_r_r;

  logic             full_s;
  logic             wr_en_s;
  logic             acr_expire_s;
  logic [7:0]       grant_type_s;
  logic             grant_acr_s;
  logic             grant_avi_s;
  logic             grant_aif_s;
  logic             pop_s;

  assign full_s             = (count_r == FULL_LVL);
  assign audio_sample_ready = !full_s;
  assign wr_en_s            = audio_sample_valid && !full_s;
  assign acr_expire_s       = (acr_timer_r == TMR_LAST);

  // Slot arbitration from pre-edge state; sources set in this cycle only count next slot.
  always_comb begin
    grant_type_s = PKT_NULL;
    grant_acr_s  = 1'b0;
    grant_avi_s  = 1'b0;
    grant_aif_s  = 1'b0;
    pop_s        = 1'b0;
    if (packet_enable) begin
      if (acr_pending_r) begin
        grant_type_s = PKT_ACR;
        grant_acr_s  = 1'b1;
      end else if (count_r >= HALF_LVL) begin
        grant_type_s = PKT_AUDIO;
        pop_s        = 1'b1;
      end else if (avi_pending_r) begin
        grant_type_s = PKT_AVI;
        grant_avi_s  = 1'b1;
      end else if (aif_pending_r) begin
        grant_type_s = PKT_AIF;
        grant_aif_s  = 1'b1;
      end else if (count_r != {CNT_W{1'b0}}) begin
        grant_type_s = PKT_AUDIO;
        pop_s        = 1'b1;
      end else begin
        grant_type_s = PKT_NULL;
      end
    end else begin
      grant_type_s = PKT_NULL;
    end
  end

  // Sample storage; pointer reset alone discards the contents.
  always_ff @(posedge clk_pixel) begin
    if (wr_en_s) begin
      fifo_l_r[wr_ptr_r] <= audio_sample_word_l;
      fifo_r_r[wr_ptr_r] <= audio_sample_word_r;
    end
  end

  // Control state: FIFO pointers, ACR timer, pending flags (set wins over grant clear), outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      acr_timer_r     <= {TMR_W{1'b0}};
      acr_pending_r   <= 1'b0;
      avi_pending_r   <= 1'b0;
      aif_pending_r   <= 1'b0;
      overflow_r      <= 1'b0;
      packet_type_r   <= PKT_NULL;
      sample_word_l_r <= 24'h000000;
      sample_word_r_r <= 24'h000000;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
        sample_word_l_r <= fifo_l_r[rd_ptr_r];
        sample_word_r_r <= fifo_r_r[rd_ptr_r];
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      acr_timer_r   <= acr_expire_s ? {TMR_W{1'b0}} : acr_timer_r + TMR_W'(1);
      acr_pending_r <= acr_expire_s || (acr_pending_r && !grant_acr_s);
      avi_pending_r <= frame_start  || (avi_pending_r && !grant_avi_s);
      aif_pending_r <= frame_start  || (aif_pending_r && !grant_aif_s);
      if (audio_sample_valid && full_s) begin
        overflow_r <= 1'b1;
      end
      if (packet_enable) begin
        packet_type_r <= grant_type_s;
      end
    end
  end

  assign packet_type    = packet_type_r;
  assign sample_word_l  = sample_word_l_r;
  assign sample_word_r  = sample_word_r_r;
  assign audio_overflow = overflow_r;

`ifdef HDMI_SCHED_DROP_COUNT_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of cycles in which an offered sample was refused.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      drop_cnt_r <= 16'h0000;
    end else if (audio_sample_valid && full_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign dropped_sample_count = drop_cnt_r;
`endif

endmodule
